twos_complement_decoder_serial: RTL and testbench
=================================================

// Module: twos_complement_decoder_serial
// PURPOSE
//  Inverse of the 8-bit two's-complement encoder in the adder/subtractor datapath.
//  Takes a two's-complement word and returns its sign and magnitude in sign-magnitude form.
//  The conversion runs bit-serially, LSB first, using the rule "copy bits up to and
//  including the first 1, invert every bit after it". One shared XOR serves all widths.
//  Valid/ready handshake on both sides. Sits between the ALU result and the display and
//  decimal formatting logic.
// PARAMETERS
//  WIDTH  8  input word width in bits, >=2; magnitude is WIDTH-1 bits
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous reset, active-low
//  in_valid     in   1        numero is valid
//  in_ready     out  1        block can accept a word (high only in IDLE)
//  numero       in   WIDTH    two's-complement input
//  out_valid    out  1        signo/magnitud/desborde are valid
//  out_ready    in   1        consumer accepts the result
//  signo        out  1        1 = negative
//  magnitud     out  WIDTH-1  absolute value
//  desborde     out  1        1 = input was the most-negative value, -2^(WIDTH-1)
//  ocupado      out  1        high in SHIFT or DONE
// BEHAVIOUR
//  Reset: rst_n low clears the block asynchronously, from any state, including mid-SHIFT.
//   - State goes to IDLE and the in-flight word is discarded.
//   - Counter, shift register, result and seen_one are cleared.
//   - Output reset values: out_valid=0, signo=0, magnitud=0, desborde=0, ocupado=0, in_ready=1.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: in_ready=1. On an edge with in_valid=1:
//     - sr <= numero, sgn <= numero[WIDTH-1], cnt <= 0, seen_one <= 0, res <= 0.
//     - Go to SHIFT.
//   - SHIFT: in_ready=0 and in_valid is ignored. Each edge processes bit b = sr[0]:
//     - r = (sgn & seen_one) ? ~b : b
//     - res <= {r, res[WIDTH-1:1]}, sr >>= 1, seen_one <= seen_one | b, cnt++.
//     - At the edge where cnt == WIDTH-1 (last bit), go to DONE.
//   - DONE: out_valid=1.
//     - signo = sgn, magnitud = res[WIDTH-2:0], desborde = res[WIDTH-1].
//     - res[WIDTH-1] is 1 only for input 100..0 (the most-negative value); magnitud is then 0.
//     - While out_ready=0, all outputs hold stable.
//     - On an edge with out_ready=1, go to IDLE and drop out_valid.
//  Latency: out_valid rises exactly WIDTH edges after the accepting edge.
//  Throughput: at most one word per WIDTH+2 cycles; no overlap between words.
//  out_valid and the result outputs are registered. in_ready and ocupado are decoded from
//   the state only.
//  Zero input: signo=0, magnitud=0, desborde=0 (no -0 is produced).
//  cnt width is clog2(WIDTH); cnt never wraps because SHIFT exits at WIDTH-1.
// TESTING
//  1. numero=8'h05 -> after 8 edges: out_valid=1, signo=0, magnitud=7'h05, desborde=0.
//  2. numero=8'hFB (-5) -> signo=1, magnitud=7'h05, desborde=0; numero=8'hFF -> signo=1,
//     magnitud=7'h01.
//  3. numero=8'h80 -> signo=1, magnitud=7'h00, desborde=1; numero=8'h00 -> all outputs 0;
//     numero=8'h7F -> signo=0, magnitud=7'h7F.
//  4. Backpressure: numero=8'h9C, out_ready=0 for 5 cycles -> signo=1, magnitud=7'h64 held
//     stable, in_ready=0. A new in_valid=1 with 8'h01 during this time is ignored.
//     Raising out_ready -> IDLE on the next edge.
//  5. Reset mid-operation: assert rst_n=0 at cnt=3 -> out_valid=0, in_ready=1 immediately.
//     After release, 8'hF0 -> signo=1, magnitud=7'h10.
//  6. Back-to-back: 8'h01 then 8'hFE accepted as soon as in_ready returns.
//     Results are in order: (0,1,0) then (1,2,0); the gap between accepts is WIDTH+2 cycles.

Source files
------------

// File: rtl/twos_complement_decoder_serial.sv
// twos_complement_decoder_serial: bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides
module twos_complement_decoder_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             signo,
  output logic [WIDTH-2:0] magnitud,
  output logic             desborde,
  output logic             ocupado
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sr, res;
  logic [CW-1:0] cnt;
  logic sgn, seen_one, last;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    ocupado = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      res <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      seen_one <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= state_n == DONE;
      if (state == IDLE && in_valid) begin
        sr <= numero;
        sgn <= numero[WIDTH-1];
        cnt <= '0;
        seen_one <= 1'b0;
        res <= '0;
      end else if (state == SHIFT) begin
        res <= {(sgn & seen_one) ^ sr[0], res[WIDTH-1:1]};
        sr <= sr >> 1;
        seen_one <= seen_one | sr[0];
        cnt <= last ? cnt : cnt + 1'b1;
      end
    end
  assign signo = sgn;
  assign magnitud = res[WIDTH-2:0];
  assign desborde = res[WIDTH-1];
endmodule

// File: tb/tb_twos_complement_decoder_serial.sv
// tb_twos_complement_decoder_serial: directed self-checking bench for the serial two's-complement decoder
module tb_twos_complement_decoder_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] numero = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signo;
  logic [6:0] magnitud;
  logic desborde;
  logic ocupado;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_first = 0;
  twos_complement_decoder_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .numero(numero), .out_valid(out_valid), .out_ready(out_ready),
    .signo(signo), .magnitud(magnitud), .desborde(desborde), .ocupado(ocupado)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic accept(input logic [7:0] v);
    int k = 0;
    in_valid = 1'b1;
    numero = v;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_wait", 32'(k < 50), 32'd1);
    t_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", {30'd0, ocupado, in_ready}, 32'b10);
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, 32'd8);
  endtask
  task automatic check_res(input string tag, input logic s, input logic [6:0] m, input logic d);
    chk({tag, "_valid"}, {29'd0, out_valid, ocupado, in_ready}, 32'b110);
    chk({tag, "_signo"}, 32'(signo), 32'(s));
    chk({tag, "_magnitud"}, 32'(magnitud), 32'(m));
    chk({tag, "_desborde"}, 32'(desborde), 32'(d));
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, out_valid, ocupado, in_ready}, 32'b001);
  endtask
  task automatic run(input string tag, input logic [7:0] v, input logic s, input logic [6:0] m, input logic d);
    accept(v);
    wait_done(tag);
    check_res(tag, s, m, d);
    release_out(tag);
  endtask
  initial begin
    #2;
    chk("reset_outputs", {27'd0, out_valid, signo, desborde, ocupado, in_ready}, 32'b00001);
    chk("reset_magnitud", 32'(magnitud), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("pos05", 8'h05, 1'b0, 7'h05, 1'b0);
    run("negFB", 8'hFB, 1'b1, 7'h05, 1'b0);
    run("negFF", 8'hFF, 1'b1, 7'h01, 1'b0);
    run("min80", 8'h80, 1'b1, 7'h00, 1'b1);
    run("zero00", 8'h00, 1'b0, 7'h00, 1'b0);
    run("max7F", 8'h7F, 1'b0, 7'h7F, 1'b0);
    accept(8'h9C);
    wait_done("bp9C");
    in_valid = 1'b1;
    numero = 8'h01;
    for (int i = 0; i < 5; i++) begin
      check_res("bp9C_hold", 1'b1, 7'h64, 1'b0);
      @(negedge clk);
    end
    check_res("bp9C_end", 1'b1, 7'h64, 1'b0);
    in_valid = 1'b0;
    release_out("bp9C");
    @(negedge clk);
    chk("bp_ignored_word", {30'd0, ocupado, in_ready}, 32'b01);
    accept(8'h33);
    repeat (3) @(negedge clk);
    chk("mid_shift_busy", {30'd0, ocupado, in_ready}, 32'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, out_valid, signo, desborde, ocupado, in_ready}, 32'b00001);
    chk("async_reset_mag", 32'(magnitud), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("negF0", 8'hF0, 1'b1, 7'h10, 1'b0);
    accept(8'h01);
    t_first = t_acc;
    wait_done("b2b01");
    check_res("b2b01", 1'b0, 7'h01, 1'b0);
    out_ready = 1'b1;
    accept(8'hFE);
    out_ready = 1'b0;
    chk("b2b_gap", t_acc - t_first, 32'd10);
    wait_done("b2bFE");
    check_res("b2bFE", 1'b1, 7'h02, 1'b0);
    release_out("b2bFE");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
